// File: rtl/clint_rsp_pkg.sv
// Shared definitions for the CLINT responder: register offsets, FSM state
// encodings, address decode and byte-lane merge helpers.
package clint_rsp_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;
    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;

    typedef enum logic [1:0] {
        SEL_MSIP     = 2'd0,
        SEL_MTIMECMP = 2'd1,
        SEL_MTIME    = 2'd2,
        SEL_NONE     = 2'd3
    } reg_sel_e;

    // Decode the 64-bit lane index (offset bits 15:3) to a register select.
    function automatic reg_sel_e decode_lane(input logic [12:0] lane);
        reg_sel_e sel;
        if (lane == CLINT_MSIP_OFF[15:3]) begin
            sel = SEL_MSIP;
        end else if (lane == CLINT_MTIMECMP_OFF[15:3]) begin
            sel = SEL_MTIMECMP;
        end else if (lane == CLINT_MTIME_OFF[15:3]) begin
            sel = SEL_MTIME;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

    function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mtime_cnt.sv
// mtime counter: prescaler dividing clk by TICK_DIV, 64-bit wrapping counter
// and a byte-strobed write port that restarts the prescaler.
module clint_mtime_cnt
    import clint_rsp_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb,
    output logic [63:0] mtime
);

    logic [31:0] presc_r;
    logic [63:0] mtime_r;
    logic        tick_s;

    assign tick_s = (presc_r == 32'(TICK_DIV - 1));
    assign mtime  = mtime_r;

    // Prescaler and counter; a write wins over the tick and drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= 32'd0;
            mtime_r <= 64'd0;
        end else if (wr_en) begin
            presc_r <= 32'd0;
            mtime_r <= apply_strb(mtime_r, wr_data, wr_strb);
        end else if (tick_s) begin
            presc_r <= 32'd0;
            mtime_r <= mtime_r + 64'd1;
        end else begin
            presc_r <= presc_r + 32'd1;
        end
    end

endmodule

// File: rtl/clint_rsp.sv
// CLINT target on the LSU request interface: msip, mtimecmp, mtime and the
// msip/mtip interrupt levels. Define CLINT_ERR_RESP_EN for error responses.
module clint_rsp
    import clint_rsp_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r_req_valid,
    output logic            r_req_ready,
    input  logic [31:0]     r_addr,
    output logic            r_resp_valid,
    input  logic            r_resp_ready,
    output logic [XLEN-1:0] r_data,
    output logic            r_err,
    input  logic            w_req_valid,
    output logic            w_req_ready,
    input  logic [31:0]     w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic [7:0]      w_strb,
    output logic            w_resp_valid,
    input  logic            w_resp_ready,
    output logic            w_err,
    output logic            msip,
    output logic            mtip
);

    r_state_e    r_state_r;
    w_state_e    w_state_r;
    logic        r_req_ready_r, r_resp_valid_r, r_err_r;
    logic        w_req_ready_r, w_resp_valid_r, w_err_r;
    logic [63:0] r_data_r;
    logic        msip_r, mtip_r;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtime_s;
    logic [31:0] r_off_s, w_off_s;
    reg_sel_e    r_sel_s, w_sel_s;
    logic [63:0] rd_val_s;
    logic        rd_err_s, wr_err_s;
    logic        r_acc_s, w_acc_s, mtime_wr_s;
    logic        unused_off_s;

    assign r_off_s      = r_addr - BASE_ADDR;
    assign w_off_s      = w_addr - BASE_ADDR;
    assign r_sel_s      = decode_lane(r_off_s[15:3]);
    assign w_sel_s      = decode_lane(w_off_s[15:3]);
    assign unused_off_s = ^{r_off_s[31:16], r_off_s[2:0], w_off_s[31:16], w_off_s[2:0]};

    assign r_acc_s    = r_req_valid && (r_state_r == R_IDLE);
    assign w_acc_s    = w_req_valid && (w_state_r == W_IDLE);
    assign mtime_wr_s = w_acc_s && (w_sel_s == SEL_MTIME);

    clint_mtime_cnt #(.TICK_DIV(TICK_DIV)) u_mtime_cnt (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mtime_wr_s),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .mtime   (mtime_s)
    );

    // Read data mux from the current (pre-write) register values.
    always_comb begin
        rd_val_s = 64'd0;
        case (r_sel_s)
            SEL_MSIP:     rd_val_s = {63'd0, msip_r};
            SEL_MTIMECMP: rd_val_s = mtimecmp_r;
            SEL_MTIME:    rd_val_s = mtime_s;
            default:      rd_val_s = 64'd0;
        endcase
    end

    // Error classification for the access being accepted.
    always_comb begin
        rd_err_s = 1'b0;
        wr_err_s = 1'b0;
`ifdef CLINT_ERR_RESP_EN
        if (r_sel_s == SEL_NONE) begin
            rd_err_s = 1'b1;
        end else begin
            rd_err_s = 1'b0;
        end
        if (w_sel_s == SEL_NONE) begin
            wr_err_s = 1'b1;
        end else if ((w_sel_s == SEL_MSIP) && (w_strb[3:0] == 4'h0) && (w_strb[7:4] != 4'h0)) begin
            wr_err_s = 1'b1;
        end else begin
            wr_err_s = 1'b0;
        end
`endif
    end

    // Read FSM: capture on accept, hold the response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r      <= R_IDLE;
            r_req_ready_r  <= 1'b1;
            r_resp_valid_r <= 1'b0;
            r_data_r       <= 64'd0;
            r_err_r        <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (r_acc_s) begin
                        r_state_r      <= R_RESP;
                        r_req_ready_r  <= 1'b0;
                        r_resp_valid_r <= 1'b1;
                        r_data_r       <= rd_val_s;
                        r_err_r        <= rd_err_s;
                    end
                end
                R_RESP: begin
                    if (r_resp_ready) begin
                        r_state_r      <= R_IDLE;
                        r_req_ready_r  <= 1'b1;
                        r_resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    r_state_r      <= R_IDLE;
                    r_req_ready_r  <= 1'b1;
                    r_resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM and msip/mtimecmp storage; registers update on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r      <= W_IDLE;
            w_req_ready_r  <= 1'b1;
            w_resp_valid_r <= 1'b0;
            w_err_r        <= 1'b0;
            msip_r         <= 1'b0;
            mtimecmp_r     <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (w_acc_s) begin
                        w_state_r      <= W_RESP;
                        w_req_ready_r  <= 1'b0;
                        w_resp_valid_r <= 1'b1;
                        w_err_r        <= wr_err_s;
                        if ((w_sel_s == SEL_MSIP) && w_strb[0]) begin
                            msip_r <= w_data[0];
                        end
                        if (w_sel_s == SEL_MTIMECMP) begin
                            mtimecmp_r <= apply_strb(mtimecmp_r, w_data, w_strb);
                        end
                    end
                end
                W_RESP: begin
                    if (w_resp_ready) begin
                        w_state_r      <= W_IDLE;
                        w_req_ready_r  <= 1'b1;
                        w_resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    w_state_r      <= W_IDLE;
                    w_req_ready_r  <= 1'b1;
                    w_resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Timer interrupt compare, one cycle behind the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_r <= 1'b0;
        end else begin
            mtip_r <= (mtime_s >= mtimecmp_r);
        end
    end

    assign r_req_ready  = r_req_ready_r;
    assign r_resp_valid = r_resp_valid_r;
    assign r_data       = r_data_r;
    assign r_err        = r_err_r;
    assign w_req_ready  = w_req_ready_r;
    assign w_resp_valid = w_resp_valid_r;
    assign w_err        = w_err_r;
    assign msip         = msip_r;
    assign mtip         = mtip_r;

endmodule
